// File: rtl/mont_mul_seq_pkg.sv
// mont_mul_seq_pkg: types, load-count constants and word selection for the multiplier sequencer
`include "mont_mul_defines.v"
package mont_mul_seq_pkg;
  localparam int WORD_W = `MONT_MUL_WORD_W;
  localparam int OPND_W = `MONT_MUL_OPND_W;
  localparam logic [1:0] OP_A = `MONT_MUL_OPERAND_A;
  localparam logic [1:0] OP_B = `MONT_MUL_OPERAND_B;
  localparam logic [1:0] OP_N = `MONT_MUL_OPERAND_N;
  localparam logic [3:0] LOADS_FULL = 4'd12;
  localparam logic [3:0] LOADS_SKIP_N = 4'd8;
  typedef enum logic [2:0] {
    ST_IDLE  = `MONT_MUL_SEQ_ST_IDLE,
    ST_LOAD  = `MONT_MUL_SEQ_ST_LOAD,
    ST_START = `MONT_MUL_SEQ_ST_START,
    ST_WAIT  = `MONT_MUL_SEQ_ST_WAIT,
    ST_DRAIN = `MONT_MUL_SEQ_ST_DRAIN
  } state_t;
  function automatic logic [1:0] load_operand(input logic [3:0] idx);
    return idx[3] ? OP_N : idx[2] ? OP_B : OP_A;
  endfunction
  function automatic logic [WORD_W-1:0] load_word(input logic [OPND_W-1:0] a, b, n, input logic [3:0] idx);
    logic [OPND_W-1:0] src;
    src = idx[3] ? n : idx[2] ? b : a;
    return src[32'(idx[1:0]) * WORD_W +: WORD_W];
  endfunction
endpackage

// File: rtl/mont_mul_defines.v
// mont_mul_defines: shared Montgomery multiplier operand, state and width encodings
`ifndef MONT_MUL_DEFINES_V
`define MONT_MUL_DEFINES_V
`define MONT_MUL_OPERAND_A 2'd0
`define MONT_MUL_OPERAND_B 2'd1
`define MONT_MUL_OPERAND_N 2'd2
`define MONT_MUL_SEQ_ST_IDLE 3'd0
`define MONT_MUL_SEQ_ST_LOAD 3'd1
`define MONT_MUL_SEQ_ST_START 3'd2
`define MONT_MUL_SEQ_ST_WAIT 3'd3
`define MONT_MUL_SEQ_ST_DRAIN 3'd4
`define MONT_MUL_WORD_W 32
`define MONT_MUL_OPND_W 128
`endif

// File: rtl/mont_mul_seq_drain.sv
// mont_mul_seq_drain: serialises a 128-bit product into four 32-bit ready/valid words
module mont_mul_seq_drain
  import mont_mul_seq_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [OPND_W-1:0] data,
  input  logic              err,
  input  logic              rsp_ready,
  output logic              rsp_valid,
  output logic [WORD_W-1:0] rsp_word,
  output logic              rsp_last,
  output logic              rsp_error,
  output logic              done
);
  logic [OPND_W-1:0] res_r;
  logic [1:0] k;
  assign done = rsp_valid && rsp_ready && rsp_last;
  // capture the product on load, then step one word per handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_word  <= '0;
      rsp_last  <= 1'b0;
      rsp_error <= 1'b0;
      k         <= '0;
    end else if (load) begin
      res_r     <= data;
      rsp_valid <= 1'b1;
      rsp_word  <= data[WORD_W-1:0];
      rsp_last  <= 1'b0;
      rsp_error <= err;
      k         <= '0;
    end else if (rsp_valid && rsp_ready) begin
      rsp_valid <= !rsp_last;
      rsp_word  <= res_r[32'(k + 2'd1) * WORD_W +: WORD_W];
      rsp_last  <= k == 2'd2;
      k         <= k + 2'd1;
    end
  end
endmodule

// File: rtl/mont_mul_seq.sv
// mont_mul_seq: Montgomery multiplier host sequencer (load, start, watchdog, drain); MONT_MUL_SEQ_N_CACHE_EN skips reloading an unchanged N
module mont_mul_seq
  import mont_mul_seq_pkg::*;
#(
  parameter int TIMEOUT = 1023
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [OPND_W-1:0] cmd_a,
  input  logic [OPND_W-1:0] cmd_b,
  input  logic [OPND_W-1:0] cmd_n,
  output logic              mm_in_valid,
  output logic [WORD_W-1:0] mm_in_word,
  output logic [1:0]        mm_in_operand,
  output logic [1:0]        mm_in_offset,
  output logic              mm_start,
  input  logic [OPND_W-1:0] mm_result,
  input  logic              mm_valid,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WORD_W-1:0] rsp_word,
  output logic              rsp_last,
  output logic              rsp_error,
  output logic              busy
);
  state_t state;
  logic [OPND_W-1:0] a_r, b_r, n_r;
  logic [3:0] idx, last_idx;
  logic [15:0] wd;
  logic drain_load, drain_done, skip_n, load_end;
  assign busy = state != ST_IDLE;
  assign load_end = state == ST_LOAD && idx == last_idx;
  assign drain_load = state == ST_WAIT && (mm_valid || wd == 16'(TIMEOUT));
`ifdef MONT_MUL_SEQ_N_CACHE_EN
  logic [OPND_W-1:0] n_cached;
  logic n_cache_vld;
  assign skip_n = n_cache_vld && cmd_n == n_cached;
  // remember the last fully loaded N; a timeout leaves the multiplier state unknown
  always_ff @(posedge clk) begin
    if (rst) begin
      n_cache_vld <= 1'b0;
    end else if (load_end && last_idx == LOADS_FULL) begin
      n_cached    <= n_r;
      n_cache_vld <= 1'b1;
    end else if (drain_load && !mm_valid) begin
      n_cache_vld <= 1'b0;
    end
  end
`else
  assign skip_n = 1'b0;
`endif
  // control FSM: the first word goes out on the accepting edge so loads start at T+1
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      cmd_ready     <= 1'b0;
      mm_in_valid   <= 1'b0;
      mm_in_word    <= '0;
      mm_in_operand <= '0;
      mm_in_offset  <= '0;
      mm_start      <= 1'b0;
      idx           <= '0;
      last_idx      <= LOADS_FULL;
      wd            <= '0;
    end else begin
      mm_in_valid <= 1'b0;
      mm_start    <= 1'b0;
      case (state)
        ST_IDLE: begin
          cmd_ready <= !(cmd_valid && cmd_ready);
          if (cmd_valid && cmd_ready) begin
            a_r           <= cmd_a;
            b_r           <= cmd_b;
            n_r           <= cmd_n;
            mm_in_valid   <= 1'b1;
            mm_in_word    <= load_word(cmd_a, cmd_b, cmd_n, 4'd0);
            mm_in_operand <= OP_A;
            mm_in_offset  <= 2'd0;
            idx           <= 4'd1;
            last_idx      <= skip_n ? LOADS_SKIP_N : LOADS_FULL;
            state         <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (load_end) begin
            mm_start <= 1'b1;
            state    <= ST_START;
          end else begin
            mm_in_valid   <= 1'b1;
            mm_in_word    <= load_word(a_r, b_r, n_r, idx);
            mm_in_operand <= load_operand(idx);
            mm_in_offset  <= idx[1:0];
            idx           <= idx + 4'd1;
          end
        end
        ST_START: begin
          wd    <= '0;
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          wd    <= wd + 16'd1;
          state <= drain_load ? ST_DRAIN : ST_WAIT;
        end
        ST_DRAIN: begin
          cmd_ready <= drain_done;
          state     <= drain_done ? ST_IDLE : ST_DRAIN;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
  mont_mul_seq_drain u_drain (
    .clk       (clk),
    .rst       (rst),
    .load      (drain_load),
    .data      (mm_valid ? mm_result : '0),
    .err       (!mm_valid),
    .rsp_ready (rsp_ready),
    .rsp_valid (rsp_valid),
    .rsp_word  (rsp_word),
    .rsp_last  (rsp_last),
    .rsp_error (rsp_error),
    .done      (drain_done)
  );
endmodule

// File: tb/tb_mont_mul_seq.sv
// tb_mont_mul_seq: scoreboard bench for the Montgomery multiplier sequencer
module tb_mont_mul_seq;
  localparam int TO = 160;
`ifdef MONT_MUL_SEQ_N_CACHE_EN
  localparam bit CACHE = 1'b1;
`else
  localparam bit CACHE = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1, cmd_valid = 1'b0, cmd_ready;
  logic [127:0] cmd_a = '0, cmd_b = '0, cmd_n = '0, mm_result = '0;
  logic mm_in_valid, mm_start, mm_valid = 1'b0, rsp_valid, rsp_ready = 1'b0;
  logic rsp_last, rsp_error, busy;
  logic [31:0] mm_in_word, rsp_word;
  logic [1:0] mm_in_operand, mm_in_offset;
  int cyc = 0, checks = 0, failures = 0, t, cnt;
  logic [35:0] load_q[$];
  logic [31:0] rsp_q[$];
  bit mvld = 1'b0;
  logic [127:0] mn, a1, b1, n1, a2, b2;

  mont_mul_seq #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_n(cmd_n),
    .mm_in_valid(mm_in_valid), .mm_in_word(mm_in_word), .mm_in_operand(mm_in_operand),
    .mm_in_offset(mm_in_offset), .mm_start(mm_start), .mm_result(mm_result), .mm_valid(mm_valid),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_word(rsp_word), .rsp_last(rsp_last),
    .rsp_error(rsp_error), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic send(input logic [127:0] a, b, n, output int tt, output int c);
    logic [127:0] src;
    c = (CACHE && mvld && n == mn) ? 8 : 12;
    for (int k = 0; k < c; k++) begin
      src = k < 4 ? a : k < 8 ? b : n;
      load_q.push_back({2'(k / 4), 2'(k % 4), src[(k % 4) * 32 +: 32]});
    end
    cmd_a = a; cmd_b = b; cmd_n = n; cmd_valid = 1'b1;
    tt = -1;
    for (int i = 0; i < 50 && tt < 0; i++)
      if (cmd_ready) tt = cyc;
      else @(negedge clk);
    check("cmd_accept", 64'(tt >= 0), 64'd1);
    if (tt < 0) $fatal(1, "no command handshake");
  endtask

  task automatic load_one();
    @(negedge clk);
    cmd_valid = 1'b0;
    check("ld_valid", 64'(mm_in_valid), 64'd1);
    if (mm_in_valid) check("ld_word", 64'({mm_in_operand, mm_in_offset, mm_in_word}), 64'(load_q.pop_front()));
  endtask

  task automatic loads(input int c, input logic [127:0] n);
    for (int j = 1; j <= c; j++) load_one();
    @(negedge clk);
    check("ld_stop", 64'(mm_in_valid), 64'd0);
    check("start", 64'(mm_start), 64'd1);
    @(negedge clk);
    check("start_pulse", 64'(mm_start), 64'd0);
    check("wait_busy", 64'(busy), 64'd1);
    if (c == 12) begin mvld = 1'b1; mn = n; end
  endtask

  task automatic result(input int d, input logic [127:0] r);
    repeat (d) @(negedge clk);
    check("rsp_idle", 64'(rsp_valid), 64'd0);
    mm_valid = 1'b1;
    mm_result = r;
    for (int k = 0; k < 4; k++) rsp_q.push_back(r[k * 32 +: 32]);
    @(negedge clk);
    mm_valid = 1'b0;
    mm_result = rnd128();
    check("rsp_start", 64'(rsp_valid), 64'd1);
  endtask

  task automatic timeout();
    for (int j = 1; j <= TO; j++) begin
      @(negedge clk);
      mm_result = rnd128();
      if (j == TO) check("to_early", 64'(rsp_valid), 64'd0);
    end
    @(negedge clk);
    check("to_fire", 64'(rsp_valid), 64'd1);
    for (int k = 0; k < 4; k++) rsp_q.push_back(32'd0);
    mvld = 1'b0;
  endtask

  task automatic drain(input int stalls, input logic err);
    logic [31:0] e;
    for (int w = 0; w < 4; w++) begin
      e = rsp_q.pop_front();
      for (int s = 0; s <= stalls; s++) begin
        if (w > 0 || s > 0) @(negedge clk);
        rsp_ready = s == stalls;
        mm_valid = stalls > 0;
        mm_result = rnd128();
        check("rsp_valid", 64'(rsp_valid), 64'd1);
        check("rsp_word", 64'(rsp_word), 64'(e));
        check("rsp_last", 64'(rsp_last), 64'(w == 3));
        check("rsp_err", 64'(rsp_error), 64'(err));
        check("rsp_busy", 64'(busy), 64'd1);
      end
    end
    @(negedge clk);
    rsp_ready = 1'b0;
    mm_valid = 1'b0;
    check("rsp_end", 64'(rsp_valid), 64'd0);
    check("idle_busy", 64'(busy), 64'd0);
    check("idle_ready", 64'(cmd_ready), 64'd1);
    check("rsp_q_empty", 64'(rsp_q.size()), 64'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "bench timeout");
  end

  initial begin
    a1 = 128'h00000004_00000003_00000002_00000001;
    b1 = 128'h0B0B0B04_0B0B0B03_0B0B0B02_0B0B0B01;
    n1 = 128'hF000000D_F000000C_F000000B_F000000A;
    a2 = 128'h12345678_9ABCDEF0_0FEDCBA9_87654321;
    b2 = 128'h55555555_AAAAAAAA_33333333_CCCCCCCC;
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    check("rst_in_valid", 64'(mm_in_valid), 64'd0);
    check("rst_start", 64'(mm_start), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_release_ready", 64'(cmd_ready), 64'd1);
    send(a1, b1, n1, t, cnt);
    loads(cnt, n1);
    result(140, 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA);
    drain(0, 1'b0);
    send(b1, a1, n1, t, cnt);
    loads(cnt, n1);
    result(5, rnd128());
    drain(2, 1'b0);
    send(a2, b2, n1, t, cnt);
    loads(cnt, n1);
    timeout();
    drain(0, 1'b1);
    send(a1, b2, n1, t, cnt);
    loads(cnt, n1);
    result(TO, rnd128());
    drain(1, 1'b0);
    send(a2, b1, n1, t, cnt);
    repeat (5) load_one();
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_in_valid", 64'(mm_in_valid), 64'd0);
    check("rst_mid_start", 64'(mm_start), 64'd0);
    check("rst_mid_ready", 64'(cmd_ready), 64'd0);
    rst = 1'b0;
    load_q.delete();
    mvld = 1'b0;
    @(negedge clk);
    check("rst_mid_release_ready", 64'(cmd_ready), 64'd1);
    check("rst_mid_busy", 64'(busy), 64'd0);
    send(a1, b1, n1, t, cnt);
    loads(cnt, n1);
    result(0, rnd128());
    drain(0, 1'b0);
    send(a2, b2, n1, t, cnt);
    loads(cnt, n1);
    result(3, rnd128());
    drain(0, 1'b0);
    send(a2, b2, n1 ^ 128'd1, t, cnt);
    loads(cnt, n1 ^ 128'd1);
    result(7, rnd128());
    drain(0, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
